// File: rtl/uc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: state codes,
// recognised opcodes and the select codes driven onto the datapath muxes.
package uc_pkg;

  // FSM state encoding (4 bits)
  localparam logic [3:0] ST_RST    = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_EXE_R  = 4'd3;
  localparam logic [3:0] ST_EXE_I  = 4'd4;
  localparam logic [3:0] ST_ADDR   = 4'd5;
  localparam logic [3:0] ST_MEM_RD = 4'd6;
  localparam logic [3:0] ST_MEM_WR = 4'd7;
  localparam logic [3:0] ST_WB_ALU = 4'd8;
  localparam logic [3:0] ST_WB_MEM = 4'd9;
  localparam logic [3:0] ST_BRANCH = 4'd10;
  localparam logic [3:0] ST_JUMP   = 4'd11;

  // Opcodes with a dedicated path; every other opcode is treated as a jump
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_I   = 6'b000001;
  localparam logic [5:0] OP_LW  = 6'b100010;
  localparam logic [5:0] OP_LWI = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000110;

  // aluOp codes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SUB   = 2'b11;

  // ALU B input selects
  localparam logic [1:0] ALUB_RT     = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  // pcSource codes
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/uc_multiciclo.sv
// Multi-cycle control FSM for the MIPS datapath. Sequences one instruction
// over 3-5 states sharing one ALU and one memory. Outputs are decoded from
// the registered state; the only input-qualified outputs are the FETCH
// write enables and the MEM_WR completion pulse, which follow mem_ready.
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           irWrite,
  output logic           iorD,
  output logic           memRead,
  output logic           memWrite,
  output logic           memtoReg,
  output logic           regDst,
  output logic           regWrite,
  output logic           aluSrcA,
  output logic [1:0]     aluSrcB,
  output logic [1:0]     aluOp,
  output logic [1:0]     pcSource,
  output logic           pcWrite,
  output logic           pcWriteCond,
  output logic           branchNe,
  output logic           instr_done
);

  logic [3:0]     state;
  logic [3:0]     state_next;
  logic [OPW-1:0] op_q;

  // State register plus opcode capture. The IR is loaded at the end of
  // FETCH, so the opcode is sampled while in DECODE and held in op_q for
  // all later states; opcode may change freely after DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RST;
      op_q  <= '0;
    end else begin
      state <= state_next;
      if (state == ST_DECODE) begin
        op_q <= opcode;
      end
    end
  end

  // Next-state logic: memory states wait for mem_ready, DECODE dispatches
  // on the live opcode, later states dispatch on the captured op_q.
  always_comb begin
    state_next = ST_RST;
    case (state)
      ST_RST:    state_next = ST_FETCH;
      ST_FETCH:  state_next = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_R:                  state_next = ST_EXE_R;
          OP_I:                  state_next = ST_EXE_I;
          OP_LW, OP_LWI, OP_SW:  state_next = ST_ADDR;
          OP_BEQ, OP_BNE:        state_next = ST_BRANCH;
          default:               state_next = ST_JUMP;
        endcase
      end
      ST_EXE_R:  state_next = ST_WB_ALU;
      ST_EXE_I:  state_next = ST_WB_ALU;
      ST_ADDR: begin
        if (op_q == OP_LW) begin
          state_next = ST_MEM_RD;
        end else if (op_q == OP_SW) begin
          state_next = ST_MEM_WR;
        end else begin
          state_next = ST_WB_ALU;
        end
      end
      ST_MEM_RD: state_next = mem_ready ? ST_WB_MEM : ST_MEM_RD;
      ST_MEM_WR: state_next = mem_ready ? ST_FETCH : ST_MEM_WR;
      ST_WB_ALU: state_next = ST_FETCH;
      ST_WB_MEM: state_next = ST_FETCH;
      ST_BRANCH: state_next = ST_FETCH;
      ST_JUMP:   state_next = ST_FETCH;
      default:   state_next = ST_RST;
    endcase
  end

  // Output decode: everything defaults to 0, each state raises only the
  // controls it needs. memRead and memWrite live in disjoint states.
  always_comb begin
    irWrite     = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    memtoReg    = 1'b0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = ALUB_RT;
    aluOp       = ALUOP_ADD;
    pcSource    = PCS_ALU;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    branchNe    = 1'b0;
    instr_done  = 1'b0;
    case (state)
      ST_FETCH: begin
        // PC+4 is computed every cycle, but only committed with the IR
        memRead = 1'b1;
        aluSrcB = ALUB_FOUR;
        irWrite = mem_ready;
        pcWrite = mem_ready;
      end
      ST_DECODE: begin
        // Speculative branch target into ALUOut
        aluSrcB = ALUB_IMM_SH;
      end
      ST_EXE_R: begin
        aluSrcA = 1'b1;
        aluSrcB = ALUB_RT;
        aluOp   = ALUOP_FUNCT;
      end
      ST_EXE_I: begin
        aluSrcA = 1'b1;
        aluSrcB = ALUB_IMM;
        aluOp   = ALUOP_FUNCT;
      end
      ST_ADDR: begin
        // lwi passes the immediate straight through as the result
        aluSrcA = 1'b1;
        aluSrcB = ALUB_IMM;
        aluOp   = (op_q == OP_LWI) ? ALUOP_PASSB : ALUOP_ADD;
      end
      ST_MEM_RD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      ST_MEM_WR: begin
        memWrite   = 1'b1;
        iorD       = 1'b1;
        instr_done = mem_ready;
      end
      ST_WB_ALU: begin
        regWrite   = 1'b1;
        regDst     = (op_q != OP_LWI);
        instr_done = 1'b1;
      end
      ST_WB_MEM: begin
        regWrite   = 1'b1;
        memtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      ST_BRANCH: begin
        aluSrcA     = 1'b1;
        aluSrcB     = ALUB_RT;
        aluOp       = ALUOP_SUB;
        pcWriteCond = 1'b1;
        pcSource    = PCS_ALUOUT;
        branchNe    = (op_q == OP_BNE);
        instr_done  = 1'b1;
      end
      ST_JUMP: begin
        pcWrite    = 1'b1;
        pcSource   = PCS_JUMP;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed bench for uc_multiciclo: walks every instruction class cycle by
// cycle and compares the full control word against hand-built expectations.
module tb_uc_multiciclo;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       irWrite, iorD, memRead, memWrite, memtoReg, regDst, regWrite;
  logic       aluSrcA, pcWrite, pcWriteCond, branchNe, instr_done;
  logic [1:0] aluSrcB, aluOp, pcSource;

  int n_vec  = 0;
  int n_miss = 0;

  uc_multiciclo #(.OPW(6)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .irWrite(irWrite), .iorD(iorD), .memRead(memRead), .memWrite(memWrite),
    .memtoReg(memtoReg), .regDst(regDst), .regWrite(regWrite),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSource(pcSource), .pcWrite(pcWrite), .pcWriteCond(pcWriteCond),
    .branchNe(branchNe), .instr_done(instr_done)
  );

  // Control word, MSB first:
  // irWrite iorD memRead memWrite memtoReg regDst regWrite aluSrcA
  // aluSrcB[1:0] aluOp[1:0] pcSource[1:0] pcWrite pcWriteCond branchNe instr_done
  logic [17:0] outs;
  assign outs = {irWrite, iorD, memRead, memWrite, memtoReg, regDst, regWrite,
                 aluSrcA, aluSrcB, aluOp, pcSource, pcWrite, pcWriteCond,
                 branchNe, instr_done};

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: expected control words per step are queued, popped by step()
  logic [17:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply mem_ready for the current cycle, compare, then advance one clock.
  task automatic step(input string tag, input logic mr);
    logic [17:0] e;
    mem_ready = mr;
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {14'd0, outs}, {14'd0, e});
    end
    check({tag, "_rdwr_excl"}, {31'd0, memRead & memWrite}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] cw(input logic irw, iord, mrd, mwr, m2r, rdst, rw, asa,
                                      input logic [1:0] asb, aop, pcs,
                                      input logic pcw, pcwc, bne, done);
    return {irw, iord, mrd, mwr, m2r, rdst, rw, asa, asb, aop, pcs, pcw, pcwc, bne, done};
  endfunction

  logic [17:0] e_zero, e_f1, e_f0, e_dec, e_exr, e_exi, e_addr, e_addr_lwi;
  logic [17:0] e_mrd, e_mw0, e_mw1, e_wbr, e_wb_lwi, e_wbm, e_bne, e_beq, e_jmp;

  initial begin
    e_zero     = '0;
    e_f1       = cw(1,0,1,0,0,0,0,0, 2'b01,2'b00,2'b00, 1,0,0,0);
    e_f0       = cw(0,0,1,0,0,0,0,0, 2'b01,2'b00,2'b00, 0,0,0,0);
    e_dec      = cw(0,0,0,0,0,0,0,0, 2'b11,2'b00,2'b00, 0,0,0,0);
    e_exr      = cw(0,0,0,0,0,0,0,1, 2'b00,2'b10,2'b00, 0,0,0,0);
    e_exi      = cw(0,0,0,0,0,0,0,1, 2'b10,2'b10,2'b00, 0,0,0,0);
    e_addr     = cw(0,0,0,0,0,0,0,1, 2'b10,2'b00,2'b00, 0,0,0,0);
    e_addr_lwi = cw(0,0,0,0,0,0,0,1, 2'b10,2'b01,2'b00, 0,0,0,0);
    e_mrd      = cw(0,1,1,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0,0,0);
    e_mw0      = cw(0,1,0,1,0,0,0,0, 2'b00,2'b00,2'b00, 0,0,0,0);
    e_mw1      = cw(0,1,0,1,0,0,0,0, 2'b00,2'b00,2'b00, 0,0,0,1);
    e_wbr      = cw(0,0,0,0,0,1,1,0, 2'b00,2'b00,2'b00, 0,0,0,1);
    e_wb_lwi   = cw(0,0,0,0,0,0,1,0, 2'b00,2'b00,2'b00, 0,0,0,1);
    e_wbm      = cw(0,0,0,0,1,0,1,0, 2'b00,2'b00,2'b00, 0,0,0,1);
    e_bne      = cw(0,0,0,0,0,0,0,1, 2'b00,2'b11,2'b01, 0,1,1,1);
    e_beq      = cw(0,0,0,0,0,0,0,1, 2'b00,2'b11,2'b01, 0,1,0,1);
    e_jmp      = cw(0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b10, 1,0,0,1);

    // Reset held for 3 cycles: all outputs 0
    rst_n = 1'b0; opcode = 6'b000000; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_hold", {14'd0, outs}, 32'd0);
    end
    rst_n = 1'b1;
    // Still in RST until the first edge, mem_ready has no effect there
    exp_q.push_back(e_zero);
    step("rst_release", 1'b1);

    // R-type: FETCH/DECODE/EXE_R/WB_ALU
    opcode = 6'b000000;
    exp_q.push_back(e_f1); exp_q.push_back(e_dec);
    exp_q.push_back(e_exr); exp_q.push_back(e_wbr);
    step("r_fetch", 1'b1); step("r_decode", 1'b1);
    step("r_exe", 1'b1);   step("r_wb", 1'b1);

    // lw with two wait cycles in MEM_RD; mem_ready=0 ignored in DECODE/ADDR/WB_MEM
    opcode = 6'b100010;
    exp_q.push_back(e_f1);  exp_q.push_back(e_dec); exp_q.push_back(e_addr);
    exp_q.push_back(e_mrd); exp_q.push_back(e_mrd); exp_q.push_back(e_mrd);
    exp_q.push_back(e_wbm);
    step("lw_fetch", 1'b1); step("lw_decode", 1'b0); step("lw_addr", 1'b0);
    step("lw_mrd_w1", 1'b0); step("lw_mrd_w2", 1'b0); step("lw_mrd_go", 1'b1);
    step("lw_wbmem", 1'b0);

    // sw with one FETCH stall, then 4 cycles
    opcode = 6'b101010;
    exp_q.push_back(e_f0); exp_q.push_back(e_f1); exp_q.push_back(e_dec);
    exp_q.push_back(e_addr); exp_q.push_back(e_mw1);
    step("sw_fetch_wait", 1'b0); step("sw_fetch", 1'b1); step("sw_decode", 1'b1);
    step("sw_addr", 1'b1); step("sw_memwr", 1'b1);

    // lwi: ADDR passes B, write-back into rt
    opcode = 6'b100011;
    exp_q.push_back(e_f1); exp_q.push_back(e_dec);
    exp_q.push_back(e_addr_lwi); exp_q.push_back(e_wb_lwi);
    step("lwi_fetch", 1'b1); step("lwi_decode", 1'b1);
    step("lwi_addr", 1'b1); step("lwi_wb", 1'b1);

    // I-arith
    opcode = 6'b000001;
    exp_q.push_back(e_f1); exp_q.push_back(e_dec);
    exp_q.push_back(e_exi); exp_q.push_back(e_wbr);
    step("i_fetch", 1'b1); step("i_decode", 1'b1);
    step("i_exe", 1'b1); step("i_wb", 1'b1);

    // bne then beq, 3 cycles each
    opcode = 6'b000110;
    exp_q.push_back(e_f1); exp_q.push_back(e_dec); exp_q.push_back(e_bne);
    step("bne_fetch", 1'b1); step("bne_decode", 1'b1); step("bne_branch", 1'b1);
    opcode = 6'b000100;
    exp_q.push_back(e_f1); exp_q.push_back(e_dec); exp_q.push_back(e_beq);
    step("beq_fetch", 1'b1); step("beq_decode", 1'b1); step("beq_branch", 1'b1);

    // Unknown opcode -> JUMP
    opcode = 6'b111111;
    exp_q.push_back(e_f1); exp_q.push_back(e_dec); exp_q.push_back(e_jmp);
    step("j_fetch", 1'b1); step("j_decode", 1'b1); step("j_jump", 1'b1);

    // lw whose opcode changes to bne after DECODE: path must stay lw
    opcode = 6'b100010;
    exp_q.push_back(e_f1); exp_q.push_back(e_dec);
    step("chg_lw_fetch", 1'b1); step("chg_lw_decode", 1'b1);
    opcode = 6'b000110;
    exp_q.push_back(e_addr); exp_q.push_back(e_mrd); exp_q.push_back(e_wbm);
    step("chg_lw_addr", 1'b1); step("chg_lw_mrd", 1'b1); step("chg_lw_wbmem", 1'b1);

    // sw whose opcode changes to R-type after DECODE, with a MEM_WR stall
    opcode = 6'b101010;
    exp_q.push_back(e_f1); exp_q.push_back(e_dec);
    step("chg_sw_fetch", 1'b1); step("chg_sw_decode", 1'b1);
    opcode = 6'b000000;
    exp_q.push_back(e_addr); exp_q.push_back(e_mw0); exp_q.push_back(e_mw1);
    step("chg_sw_addr", 1'b1); step("chg_sw_memwr_wait", 1'b0); step("chg_sw_memwr", 1'b1);

    // Reset mid-instruction while in MEM_RD: memRead must drop before the next edge
    opcode = 6'b100010;
    exp_q.push_back(e_f1); exp_q.push_back(e_dec); exp_q.push_back(e_addr);
    step("rst_lw_fetch", 1'b1); step("rst_lw_decode", 1'b1); step("rst_lw_addr", 1'b1);
    mem_ready = 1'b0;
    #1;
    check("rst_lw_in_mrd", {14'd0, outs}, {14'd0, e_mrd});
    rst_n = 1'b0;
    #1;
    check("rst_async_memread", {31'd0, memRead}, 32'd0);
    check("rst_async_all", {14'd0, outs}, 32'd0);
    @(posedge clk); #1;
    check("rst_mid_hold", {14'd0, outs}, 32'd0);
    rst_n = 1'b1;
    // After release: RST for one cycle, then FETCH; op_q cleared so a fresh
    // beq runs its own path
    opcode = 6'b000100;
    exp_q.push_back(e_zero); exp_q.push_back(e_f1);
    exp_q.push_back(e_dec);  exp_q.push_back(e_beq); exp_q.push_back(e_f1);
    step("rst2_release", 1'b1); step("rst2_fetch", 1'b1);
    step("rst2_decode", 1'b1); step("rst2_branch", 1'b1); step("rst2_refetch", 1'b1);

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
